reg32_wr_arbiter: RTL and testbench
===================================

Name: reg32_wr_arbiter

Overview:
- Round-robin write arbiter and owner of a shared 32-bit register, with asynchronous preset and positive-edge clock.
- Up to N_REQ requesters write the register through valid/ready handshakes with byte enables.
- Supports a locked burst mode with a watchdog, a write-event pulse and a saturating write counter.
- Sits between bus-side requesters and the register file's storage flops.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PRESET_VAL, 32'hFFFF_FFFF, register value forced by reset.
- LOCK_TIMEOUT, 16, idle cycles a lock owner may hold the grant without a transfer before forced release.
- CNT_W, 16, width of the write counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester write request.
- req_data  in  32*N_REQ  write data; slice i belongs to requester i.
- req_be  in  4*N_REQ  byte enables; slice i belongs to requester i.
- req_lock  in  N_REQ  keep ownership after this transfer.
- req_ready  out  N_REQ  one-hot grant, combinational.
- q  out  32  register contents.
- wr_pulse  out  1  high for one cycle after any register write.
- last_wr_id  out  $clog2(N_REQ)  index of the last writer.
- wr_count  out  CNT_W  saturating count of accepted transfers.
- lock_active  out  1  FSM is in LOCKED.
- lock_timeout_err  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - q=PRESET_VAL, FSM=IDLE, rr_ptr=0.
  - wr_pulse=0, last_wr_id=0, wr_count=0.
  - lock_active=0, lock_timeout_err=0, timer=0.
- Release is synchronous to the next rising edge. Reset mid-burst drops the lock and discards the cycle's transfer.
- A transfer happens when req_valid[i] & req_ready[i].
  - At that clk edge each byte k of q with req_be[i][k]=1 takes req_data[i][8k+7:8k]; the other bytes hold.
  - q is visible one cycle after the handshake.
  - be=0 still counts as a transfer, with no data change.
- req_ready is at most one-hot and combinational from req_valid, the FSM state and rr_ptr. It never depends on req_data.
- IDLE state:
  - Grant the first valid requester at or after rr_ptr, searching cyclically.
  - On a transfer, rr_ptr becomes the granted index + 1, wrapping modulo N_REQ.
  - If the transfer had req_lock[i]=1: owner becomes i, next state is LOCKED, timer=0.
- LOCKED state:
  - Only the owner may be granted; every other ready is 0.
  - A transfer with lock=0 returns to IDLE. A transfer with lock=1 stays in LOCKED and clears the timer.
  - The timer increments on cycles without a transfer, whether or not the owner is valid.
  - When the timer reaches LOCK_TIMEOUT-1 with no transfer, the next edge goes to IDLE and pulses lock_timeout_err for 1 cycle.
  - A transfer in that same cycle takes precedence: it completes and no error is raised.
  - rr_ptr is not updated in LOCKED. It was already advanced past the owner on lock entry.
- wr_pulse and last_wr_id are registered and update on the edge after the handshake, the same edge q changes.
- wr_count increments per transfer and saturates at all-ones.
- lock_active = (state==LOCKED).
- No X propagation: q data bits are sampled only from the granted slice.

Decomposition:
- Package reg32_arb_pkg holds:
  - the state enum {IDLE, LOCKED};
  - a localparam for the index width;
  - a byte-merge function (old, new, be) -> merged.
- One sub-module, rr_pick, is natural: combinational round-robin priority select (valid, ptr) -> one-hot grant plus index.
- The parent holds the FSM, the 32-bit storage, the timer and the counter.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle.
  - Required: q=FFFF_FFFF immediately, all other outputs 0, no ready while rst is high.
- Round-robin fairness: N_REQ=4, all valid continuously, lock=0, be=F, data=i.
  - Required: grants in order 0,1,2,3,0; q follows the same sequence one cycle later; wr_count=5.
- Byte enables: q=FFFF_FFFF, req1 writes data=1234_5678 with be=0101.
  - Required: q=FF34_FF78, wr_pulse=1, last_wr_id=1.
- Locked burst: req2 transfers with lock=1, then 3 more transfers with lock=1,1,0 while req0 is valid throughout.
  - Required: req0 is not granted during the burst; req0 is granted on the cycle after the lock=0 transfer.
- Lock timeout: req3 locks and then drops valid.
  - Required: after 16 cycles, lock_timeout_err pulses once and lock_active=0; a pending req1 is then granted.
- Saturation: CNT_W=4 with 20 transfers.
  - Required: wr_count=15 and holds.

Source files
------------

// File: rtl/reg32_arb_pkg.sv
// Shared types and helpers for the 32-bit register write arbiter.
package reg32_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int REG_BYTES = 4;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int arb_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] merge_bytes(
        input logic [31:0]          old_val,
        input logic [31:0]          new_val,
        input logic [REG_BYTES-1:0] be
    );
        logic [31:0] merged;
        merged = old_val;
        for (int k = 0; k < REG_BYTES; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_val[8*k +: 8];
            end else begin
                merged[8*k +: 8] = old_val[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/reg32_wr_arbiter_rr_pick.sv
// Combinational round-robin select: first valid requester at or after ptr, cyclically.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Cyclic priority scan starting at the pointer.
    always_comb begin
        int j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && valid_i[j]) begin
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
                any_o      = 1'b1;
            end else begin
                any_o      = any_o;
            end
        end
    end

endmodule

// File: rtl/reg32_wr_arbiter.sv
// Round-robin write arbiter owning a shared 32-bit register, with locked bursts,
// a lock watchdog, a write-event pulse and a saturating write counter.
module reg32_wr_arbiter
    import reg32_arb_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter logic [31:0] PRESET_VAL   = 32'hFFFF_FFFF,
    parameter int          LOCK_TIMEOUT = 16,
    parameter int          CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [32*N_REQ-1:0]        req_data,
    input  logic [4*N_REQ-1:0]         req_be,
    input  logic [N_REQ-1:0]           req_lock,
    output logic [N_REQ-1:0]           req_ready,
    output logic [31:0]                q,
    output logic                       wr_pulse,
    output logic [$clog2(N_REQ)-1:0]   last_wr_id,
    output logic [CNT_W-1:0]           wr_count,
    output logic                       lock_active,
    output logic                       lock_timeout_err
);

    localparam int               IDX_W    = arb_idx_w(N_REQ);
    localparam int               TMR_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  owner_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  rr_ptr_d;
    logic [IDX_W-1:0]  last_id_q;
    logic [TMR_W-1:0]  timer_q;
    logic [31:0]       reg_q;
    logic [31:0]       reg_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              wr_pulse_q;
    logic              err_q;

    logic [N_REQ-1:0]  pick_grant_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_any_s;
    logic [N_REQ-1:0]  ready_s;
    logic [IDX_W-1:0]  gnt_idx_s;
    logic              xfer_s;
    logic              xfer_lock_s;
    logic [31:0]       wdata_s;
    logic [3:0]        wbe_s;

    rr_pick #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_rr_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    // Grant selection: round-robin when idle, owner-only when locked, none in reset.
    always_comb begin
        ready_s   = '0;
        gnt_idx_s = pick_idx_s;
        if (rst) begin
            ready_s = '0;
        end else if (state_q == LOCKED) begin
            gnt_idx_s        = owner_q;
            ready_s[owner_q] = req_valid[owner_q];
        end else if (pick_any_s) begin
            ready_s = pick_grant_s;
        end else begin
            ready_s = '0;
        end
    end

    // Write-side mux reads only the granted slice so idle slices cannot leak X into q.
    always_comb begin
        wdata_s = 32'h0000_0000;
        wbe_s   = 4'h0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ready_s[i]) begin
                wdata_s = req_data[32*i +: 32];
                wbe_s   = req_be[4*i +: 4];
            end else begin
                wdata_s = wdata_s;
            end
        end
    end

    assign xfer_s      = |(req_valid & ready_s);
    assign xfer_lock_s = |(req_lock & ready_s);

    // Next-state values for the pointer, storage and counter.
    always_comb begin
        rr_ptr_d = (gnt_idx_s == IDX_LAST) ? '0 : gnt_idx_s + IDX_W'(1);
        reg_d    = merge_bytes(reg_q, wdata_s, wbe_s);
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Arbiter FSM with register storage, watchdog timer and event outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            last_id_q  <= '0;
            timer_q    <= '0;
            reg_q      <= PRESET_VAL;
            cnt_q      <= '0;
            wr_pulse_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_pulse_q <= xfer_s;
            err_q      <= 1'b0;
            if (xfer_s) begin
                reg_q     <= reg_d;
                last_id_q <= gnt_idx_s;
                cnt_q     <= cnt_d;
            end
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (xfer_s) begin
                        rr_ptr_q <= rr_ptr_d;
                        if (xfer_lock_s) begin
                            state_q <= LOCKED;
                            owner_q <= gnt_idx_s;
                        end
                    end
                end
                LOCKED: begin
                    // A transfer on the final watchdog cycle wins over the timeout.
                    if (xfer_s) begin
                        timer_q <= '0;
                        if (!xfer_lock_s) begin
                            state_q <= IDLE;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign req_ready        = ready_s;
    assign q                = reg_q;
    assign wr_pulse         = wr_pulse_q;
    assign last_wr_id       = last_id_q;
    assign wr_count         = cnt_q;
    assign lock_active      = (state_q == LOCKED);
    assign lock_timeout_err = err_q;

endmodule

// File: tb/tb_reg32_wr_arbiter.sv
// Self-checking bench for reg32_wr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model (main instance CNT_W=16, second CNT_W=4).
module tb_reg32_wr_arbiter;

    localparam int          N   = 4;
    localparam logic [31:0] PRE = 32'hFFFF_FFFF;
    localparam int          TO  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_lock;
    logic [32*N-1:0] req_data;
    logic [4*N-1:0]  req_be;

    logic [N-1:0]    req_ready, req_ready_s;
    logic [31:0]     q, q_s;
    logic            wr_pulse, wr_pulse_s;
    logic [1:0]      last_wr_id, last_wr_id_s;
    logic [15:0]     wr_count;
    logic [3:0]      wr_count_s;
    logic            lock_active, lock_active_s;
    logic            lock_timeout_err, lock_timeout_err_s;

    int checks = 0;
    int errors = 0;

    // Reference model: owner (-1 = unlocked), pointer, idle timer, register image, count.
    int          own, ptr, tmr, mcnt, mlast, eg;
    logic [31:0] mq;
    bit          mpulse, merr;

    always #5 clk = ~clk;

    reg32_wr_arbiter #(.N_REQ(N), .PRESET_VAL(PRE), .LOCK_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_be(req_be),
        .req_lock(req_lock), .req_ready(req_ready), .q(q), .wr_pulse(wr_pulse),
        .last_wr_id(last_wr_id), .wr_count(wr_count), .lock_active(lock_active),
        .lock_timeout_err(lock_timeout_err)
    );

    reg32_wr_arbiter #(.N_REQ(N), .PRESET_VAL(PRE), .LOCK_TIMEOUT(TO), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_be(req_be),
        .req_lock(req_lock), .req_ready(req_ready_s), .q(q_s), .wr_pulse(wr_pulse_s),
        .last_wr_id(last_wr_id_s), .wr_count(wr_count_s), .lock_active(lock_active_s),
        .lock_timeout_err(lock_timeout_err_s)
    );

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [52:0] exp_main();
        return {mq, mpulse, 2'(mlast), 16'(sat(mcnt, 65535)), (own >= 0), merr};
    endfunction

    function automatic logic [40:0] exp_small();
        return {mq, mpulse, 2'(mlast), 4'(sat(mcnt, 15)), (own >= 0), merr};
    endfunction

    function automatic int model_grant();
        if (own >= 0) return req_valid[own] ? own : -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        own = -1; ptr = 0; tmr = 0; mcnt = 0; mlast = 0;
        mq = PRE; mpulse = 1'b0; merr = 1'b0;
    endtask

    task automatic model_commit(input int g);
        mpulse = 1'b0;
        merr   = 1'b0;
        if (g >= 0) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[4*g + b]) mq[8*b +: 8] = req_data[32*g + 8*b +: 8];
            end
            mlast  = g;
            mpulse = 1'b1;
            mcnt++;
            if (own < 0) begin
                ptr = (g + 1) % N;
                if (req_lock[g]) begin own = g; tmr = 0; end
            end else if (req_lock[g]) begin
                tmr = 0;
            end else begin
                own = -1;
            end
        end else if (own >= 0) begin
            if (tmr == TO - 1) begin own = -1; merr = 1'b1; tmr = 0; end
            else tmr++;
        end
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_lock = '0; req_data = '0; req_be = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic settle();
        #1;
        eg = model_grant();
    endtask

    task automatic tick();
        @(posedge clk); #1;
        model_commit(eg);
    endtask

    task automatic test_reset();
        reset_dut();
        req_valid = 4'b0001; req_lock = 4'b0001; req_be = '1; req_data = {4{32'h0BAD_F00D}};
        settle();
        tick();
        checks++;
        if (lock_active !== 1'b1 || q !== 32'h0BAD_F00D)
            begin errors++; $display("FAIL reset_prelock: lock=%b q=%h want lock=1 q=0badf00d", lock_active, q); end
        req_valid = '1; req_lock = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({q, wr_pulse, last_wr_id, wr_count, lock_active, lock_timeout_err, req_ready} !==
            {PRE, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 4'b0000})
            begin errors++; $display("FAIL reset_async: q=%h pulse=%b id=%0d cnt=%0d lock=%b err=%b rdy=%b want q=ffffffff rest 0",
                q, wr_pulse, last_wr_id, wr_count, lock_active, lock_timeout_err, req_ready); end
        checks++;
        if (wr_count_s !== 4'h0 || req_ready_s !== 4'b0000)
            begin errors++; $display("FAIL reset_small: cnt=%0d rdy=%b want 0 0", wr_count_s, req_ready_s); end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 4'b0000 || q !== PRE)
            begin errors++; $display("FAIL reset_hold: rdy=%b q=%h want 0000 ffffffff", req_ready, q); end
        rst = 1'b0;
        model_reset();
        clear_inputs();
    endtask

    task automatic test_byte_enable();
        reset_dut();
        req_valid = 4'b0010;
        req_data[32 +: 32] = 32'h1234_5678;
        req_be[4 +: 4]     = 4'b0101;
        settle();
        checks++;
        if (req_ready !== 4'b0010)
            begin errors++; $display("FAIL be_ready: got %b want 0010", req_ready); end
        tick();
        checks++;
        if (q !== 32'hFF34_FF78 || wr_pulse !== 1'b1 || last_wr_id !== 2'd1)
            begin errors++; $display("FAIL be_merge: q=%h pulse=%b id=%0d want ff34ff78 1 1", q, wr_pulse, last_wr_id); end
        req_valid = '0;
        settle();
        tick();
        checks++;
        if (wr_pulse !== 1'b0 || q !== 32'hFF34_FF78)
            begin errors++; $display("FAIL be_pulse_once: pulse=%b q=%h want 0 ff34ff78", wr_pulse, q); end
    endtask

    task automatic test_round_robin();
        reset_dut();
        req_valid = '1; req_lock = '0; req_be = '1;
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = i;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if (req_ready !== onehot(c % N) || req_ready !== onehot(eg))
                begin errors++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, onehot(c % N)); end
            tick();
            checks++;
            if (q !== 32'(c % N) || last_wr_id !== 2'(c % N))
                begin errors++; $display("FAIL rr_q c%0d: q=%h id=%0d want %0d", c, q, last_wr_id, c % N); end
        end
        checks++;
        if (wr_count !== 16'd5 || wr_count_s !== 4'd5)
            begin errors++; $display("FAIL rr_count: got %0d/%0d want 5", wr_count, wr_count_s); end
    endtask

    task automatic test_locked_burst();
        reset_dut();
        req_valid = 4'b0010; req_be = '1; req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        settle();
        tick();
        req_valid = 4'b0101;
        for (int c = 0; c < 4; c++) begin
            req_lock = (c < 3) ? 4'b0100 : 4'b0000;
            req_data[64 +: 32] = $urandom();
            settle();
            checks++;
            if (req_ready !== 4'b0100 || lock_active !== (c > 0))
                begin errors++; $display("FAIL burst_c%0d: rdy=%b lock=%b want 0100 %b", c, req_ready, lock_active, c > 0); end
            tick();
        end
        req_valid = 4'b0001; req_lock = '0;
        settle();
        checks++;
        if (req_ready !== 4'b0001 || lock_active !== 1'b0)
            begin errors++; $display("FAIL burst_release: rdy=%b lock=%b want 0001 0", req_ready, lock_active); end
        tick();
        checks++;
        if ({q, wr_pulse, last_wr_id, wr_count, lock_active, lock_timeout_err} !== exp_main())
            begin errors++; $display("FAIL burst_state: got %h want %h", {q, wr_pulse, last_wr_id, wr_count, lock_active, lock_timeout_err}, exp_main()); end
    endtask

    task automatic test_lock_timeout();
        int n_err;
        n_err = 0;
        reset_dut();
        req_valid = 4'b1000; req_lock = 4'b1000; req_be = '1; req_data = {4{32'hA5A5_0003}};
        settle();
        tick();
        checks++;
        if (lock_active !== 1'b1)
            begin errors++; $display("FAIL to_enter: lock=%b want 1", lock_active); end
        req_valid = 4'b0010; req_lock = '0;
        for (int c = 0; c < TO; c++) begin
            settle();
            checks++;
            if (req_ready !== 4'b0000)
                begin errors++; $display("FAIL to_blocked c%0d: rdy=%b want 0000", c, req_ready); end
            tick();
            if (lock_timeout_err === 1'b1) n_err++;
            checks++;
            if (lock_timeout_err !== (c == TO - 1) || lock_active !== (c != TO - 1))
                begin errors++; $display("FAIL to_c%0d: err=%b lock=%b want %b %b", c, lock_timeout_err, lock_active, c == TO - 1, c != TO - 1); end
        end
        settle();
        checks++;
        if (req_ready !== 4'b0010)
            begin errors++; $display("FAIL to_regrant: rdy=%b want 0010", req_ready); end
        tick();
        checks++;
        if (n_err != 1 || lock_timeout_err !== 1'b0)
            begin errors++; $display("FAIL to_pulse_once: pulses=%0d err=%b want 1 0", n_err, lock_timeout_err); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            req_valid = ((c % 120) >= 95) ? 4'b0000 : 4'($urandom_range(15));
            req_lock  = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'b0000;
            for (int i = 0; i < N; i++) begin
                req_data[32*i +: 32] = $urandom();
                req_be[4*i +: 4]     = 4'($urandom_range(15));
            end
            settle();
            checks++;
            if (req_ready !== onehot(eg) || req_ready_s !== onehot(eg))
                begin errors++; $display("FAIL rnd_ready c%0d: got %b/%b want %b", c, req_ready, req_ready_s, onehot(eg)); end
            tick();
            checks++;
            if ({q, wr_pulse, last_wr_id, wr_count, lock_active, lock_timeout_err} !== exp_main())
                begin errors++; $display("FAIL rnd_main c%0d: got %h want %h", c, {q, wr_pulse, last_wr_id, wr_count, lock_active, lock_timeout_err}, exp_main()); end
            checks++;
            if ({q_s, wr_pulse_s, last_wr_id_s, wr_count_s, lock_active_s, lock_timeout_err_s} !== exp_small())
                begin errors++; $display("FAIL rnd_small c%0d: got %h want %h", c, {q_s, wr_pulse_s, last_wr_id_s, wr_count_s, lock_active_s, lock_timeout_err_s}, exp_small()); end
        end
        checks++;
        if (mcnt < 20 || wr_count_s !== 4'hF || wr_count !== 16'(mcnt))
            begin errors++; $display("FAIL saturation: small=%0d main=%0d transfers=%0d want 15 and %0d", wr_count_s, wr_count, mcnt, mcnt); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        eg = -1;
        test_reset();
        test_byte_enable();
        test_round_robin();
        test_locked_burst();
        test_lock_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
